// File: rtl/seq_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | seq_pkg : shared state encoding and clog2 helper for seq blocks |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } seq_state_t;

   // Ceiling log2, never below 1 so a counter always has at least one bit.
   function automatic int unsigned seq_clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_shreg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | seq_shreg : loadable shift register with selectable direction   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module seq_shreg
   import seq_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_ser
);

   logic [WIDTH-1:0] r_sh;
   logic [WIDTH-1:0] w_sh_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sh <= '0;
      end else if (i_load) begin
         r_sh <= i_data;
      end else if (i_shift) begin
         r_sh <= w_sh_nxt;
      end
   end

   generate
      if (MSB_FIRST) begin : g_msb
         assign w_sh_nxt = {r_sh[WIDTH-2:0], 1'b0};
         assign o_ser    = r_sh[WIDTH-1];
      end else begin : g_lsb
         assign w_sh_nxt = {1'b0, r_sh[WIDTH-1:1]};
         assign o_ser    = r_sh[0];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/seq_tx.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | seq_tx : parallel-to-serial pattern transmitter with done pulse |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module seq_tx
   import seq_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
)(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            abort,
   input  logic [WIDTH-1:0]                data_in,
   output logic                            ready,
   output logic                            dout,
   output logic                            dout_valid,
   output logic                            done,
   output logic [seq_clog2(WIDTH)-1:0]     bit_idx
);

   localparam int                IDX_W  = seq_clog2(WIDTH);
   localparam logic [IDX_W-1:0]  C_LAST = IDX_W'(WIDTH - 1);

   seq_state_t       r_state;
   seq_state_t       w_state_nxt;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_nxt;
   logic             r_ready;
   logic             r_valid;
   logic             r_done;
   logic             w_load;
   logic             w_shift;
   logic             w_ser;

   seq_shreg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (data_in),
      .o_ser   (w_ser)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_ready <= 1'b1;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_ready <= (w_state_nxt == S_IDLE);
         r_valid <= (w_state_nxt == S_SHIFT);
         r_done  <= (w_state_nxt == S_DONE);
      end
   end

   // Abort takes priority over the last-bit transition so no done pulse escapes.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_SHIFT;
               w_idx_nxt   = '0;
               w_load      = 1'b1;
            end
         end
         S_SHIFT: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_idx_nxt   = '0;
            end else if (r_idx == C_LAST) begin
               w_state_nxt = S_DONE;
               w_idx_nxt   = '0;
            end else begin
               w_shift     = 1'b1;
               w_idx_nxt   = r_idx + 1'b1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   assign ready      = r_ready;
   assign dout_valid = r_valid;
   assign done       = r_done;
   assign bit_idx    = r_idx;
   assign dout       = r_valid ? w_ser : IDLE_BIT;

endmodule
`default_nettype wire

// File: tb/tb_seq_tx.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_seq_tx : scoreboard bench for seq_tx (7-bit MSB, 8-bit LSB)  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_seq_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       start7, abort7;
   logic [6:0] data7;
   logic       ready7, dout7, valid7, done7;
   logic [2:0] idx7;
   logic       start8, abort8;
   logic [7:0] data8;
   logic       ready8, dout8, valid8, done8;
   logic [2:0] idx8;

   int errors = 0;
   int checks = 0;
   bit exp_q[$];

   always #5 clk = ~clk;

   seq_tx #(.WIDTH(7), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut7 (
      .clk(clk), .rst(rst), .start(start7), .abort(abort7), .data_in(data7),
      .ready(ready7), .dout(dout7), .dout_valid(valid7), .done(done7), .bit_idx(idx7)
   );

   seq_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .abort(abort8), .data_in(data8),
      .ready(ready8), .dout(dout8), .dout_valid(valid8), .done(done8), .bit_idx(idx8)
   );

   // Observed vector order: {valid, done, ready, dout, idx}
   task automatic test_reset();
      rst = 1'b0;
      start7 = 1'b0; abort7 = 1'b0; data7 = '0;
      start8 = 1'b0; abort8 = 1'b0; data8 = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({valid7, done7, ready7, dout7, idx7, valid8, done8, ready8, dout8, idx8} !== 14'b0010000_0010000) begin
         errors++;
         $display("FAIL reset_hold: got %b required %b",
                  {valid7, done7, ready7, dout7, idx7, valid8, done8, ready8, dout8, idx8}, 14'b0010000_0010000);
      end
      rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if ({valid7, done7, ready7, dout7, idx7, valid8, done8, ready8, dout8, idx8} !== 14'b0010000_0010000) begin
            errors++;
            $display("FAIL reset_idle c%0d: got %b required %b", c,
                     {valid7, done7, ready7, dout7, idx7, valid8, done8, ready8, dout8, idx8}, 14'b0010000_0010000);
         end
      end
   endtask

   task automatic test_detector7();
      logic       ebit;
      logic [6:0] w;
      w = 7'b1001011;
      data7 = w;
      start7 = 1'b1;
      for (int k = 6; k >= 0; k--) exp_q.push_back(w[k]);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         if (k == 0) start7 = 1'b0;
         ebit = exp_q.pop_front();
         checks++;
         if ({valid7, done7, ready7, dout7, idx7} !== {1'b1, 1'b0, 1'b0, ebit, 3'(k)}) begin
            errors++;
            $display("FAIL det7_bit%0d: got %b required %b", k,
                     {valid7, done7, ready7, dout7, idx7}, {1'b1, 1'b0, 1'b0, ebit, 3'(k)});
         end
      end
      @(negedge clk);
      checks++;
      if ({valid7, done7, ready7, dout7, idx7} !== 7'b0100000) begin
         errors++;
         $display("FAIL det7_done: got %b required %b", {valid7, done7, ready7, dout7, idx7}, 7'b0100000);
      end
      @(negedge clk);
      checks++;
      if ({valid7, done7, ready7, dout7, idx7} !== 7'b0010000) begin
         errors++;
         $display("FAIL det7_ready: got %b required %b", {valid7, done7, ready7, dout7, idx7}, 7'b0010000);
      end
   endtask

   // Full 8-bit LSB-first frame; optionally pokes start with 8'hFF while busy.
   task automatic test_frame8(input logic [7:0] w, input bit inject_busy, input string tag);
      logic       ev, edone, erdy, ebit;
      logic [2:0] eidx;
      int         ndone;
      ndone = 0;
      checks++;
      if (ready8 !== 1'b1) begin
         errors++;
         $display("FAIL %s_pre_ready: got %b required 1", tag, ready8);
      end
      data8 = w;
      start8 = 1'b1;
      for (int k = 0; k < 8; k++) exp_q.push_back(w[k]);
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         if (cyc == 1) start8 = 1'b0;
         if (inject_busy && cyc == 3) begin start8 = 1'b1; data8 = 8'hFF; end
         if (inject_busy && cyc == 6) start8 = 1'b0;
         ev    = (cyc <= 8);
         edone = (cyc == 9);
         erdy  = (cyc >= 10);
         ebit  = ev ? exp_q.pop_front() : 1'b0;
         eidx  = ev ? 3'(cyc - 1) : 3'd0;
         if (done8 === 1'b1) ndone++;
         checks++;
         if ({valid8, done8, ready8, dout8, idx8} !== {ev, edone, erdy, ebit, eidx}) begin
            errors++;
            $display("FAIL %s_cyc%0d: got %b required %b", tag, cyc,
                     {valid8, done8, ready8, dout8, idx8}, {ev, edone, erdy, ebit, eidx});
         end
      end
      checks++;
      if (ndone != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_done_count: got %0d pulses (%0d bits left) required 1 (0)", tag, ndone, exp_q.size());
      end
   endtask

   task automatic test_abort();
      logic ebit;
      int   ndone;
      ndone = 0;
      data8 = 8'h96;
      start8 = 1'b1;
      for (int k = 0; k < 8; k++) exp_q.push_back(data8[k]);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 0) start8 = 1'b0;
         ebit = exp_q.pop_front();
         checks++;
         if ({valid8, dout8, idx8} !== {1'b1, ebit, 3'(k)}) begin
            errors++;
            $display("FAIL abort_bit%0d: got %b required %b", k, {valid8, dout8, idx8}, {1'b1, ebit, 3'(k)});
         end
      end
      abort8 = 1'b1;
      exp_q.delete();
      @(negedge clk);
      abort8 = 1'b0;
      checks++;
      if ({valid8, done8, ready8, dout8, idx8} !== 7'b0010000) begin
         errors++;
         $display("FAIL abort_idle: got %b required %b", {valid8, done8, ready8, dout8, idx8}, 7'b0010000);
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done8 === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         errors++;
         $display("FAIL abort_no_done: got %0d pulses required 0", ndone);
      end
      test_frame8(8'h5A, 1'b0, "post_abort");
   endtask

   task automatic test_async_reset();
      data8 = 8'hC3;
      start8 = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) start8 = 1'b0;
      end
      checks++;
      if ({valid8, idx8} !== 4'b1101) begin
         errors++;
         $display("FAIL arst_pre: got %b required %b", {valid8, idx8}, 4'b1101);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({valid8, done8, ready8, dout8, idx8} !== 7'b0010000) begin
         errors++;
         $display("FAIL arst_immediate: got %b required %b", {valid8, done8, ready8, dout8, idx8}, 7'b0010000);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({valid8, done8, ready8, dout8, idx8} !== 7'b0010000) begin
         errors++;
         $display("FAIL arst_released: got %b required %b", {valid8, done8, ready8, dout8, idx8}, 7'b0010000);
      end
      test_frame8(8'h81, 1'b0, "post_arst");
   endtask

   initial begin
      test_reset();
      test_detector7();
      test_frame8(8'hA5, 1'b0, "lsb8");
      test_frame8(8'h3C, 1'b1, "busy");
      test_abort();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
